ctrl_link_scheduler: RTL and testbench

- Sequences the control-package transceiver and shares it between NUM_REQ requesters.
- Round-robin arbitration selects one requester's 128-bit package and presents it to the transceiver with setup time, then pulses tx_start.
- Waits for TX completion and RX loop-back match, with a timeout and bounded retries.
- Reports a per-requester pass/fail completion and keeps saturating link statistics.

---
 rtl/ctrl_link_pkg.sv | 18 +
 rtl/ctrl_link_scheduler_rr_arbiter.sv | 29 ++
 rtl/ctrl_link_scheduler.sv | 154 +++++++++++++++
 tb/tb_ctrl_link_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_link_pkg.sv
// Shared definitions for the control-link scheduler: FSM state encoding and
// the package/wire bit counts used by the transceiver handshake.
package ctrl_link_pkg;

    localparam int CTRL_PKG_BITS  = 128;
    localparam int CTRL_WIRE_BITS = 144;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT_TX = 3'd3,
        WAIT_RX = 3'd4,
        PASS    = 3'd5,
        FAIL    = 3'd6
    } state_t;

endpackage

// File: rtl/ctrl_link_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward with wrap-around.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      grant,
    output logic               any_req
);

    always_comb begin
        logic found;
        int   idx;
        grant   = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                grant = IW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_link_scheduler.sv
// Shares the control-package transceiver between NUM_REQ requesters: round-robin
// grant, package setup, start pulse, completion/loop-back wait with timeout and retries.
module ctrl_link_scheduler
    import ctrl_link_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 512,
    parameter int MAX_RETRY   = 3,
    parameter int TW          = 10
) (
    input  logic                              sys_clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*CTRL_PKG_BITS-1:0]  req_package,
    output logic [NUM_REQ-1:0]                done,
    output logic                              done_ok,
    output logic                              busy,
    output logic                              tx_start,
    output logic [CTRL_PKG_BITS-1:0]          tx_package_o,
    input  logic                              tx_done,
    input  logic                              rx_good,
    input  logic [7:0]                        rx_bit_cnt,
    output logic [15:0]                       pass_cnt,
    output logic [15:0]                       fail_cnt
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
        return (int'(g) + 1 >= NUM_REQ) ? '0 : g + IW'(1);
    endfunction

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] arb_grant;
    logic          arb_any;
    logic [3:0]    retry;
    logic [TW-1:0] timer;
    logic          load_cnt;

    logic               rx_ok;
    logic               timed_out;
    logic               last_try;
    logic [NUM_REQ-1:0] grant_onehot;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .grant   (arb_grant),
        .any_req (arb_any)
    );

    assign rx_ok        = rx_good && (rx_bit_cnt == 8'(CTRL_WIRE_BITS));
    assign timed_out    = (timer >= TW'(TIMEOUT_CYC - 1));
    assign last_try     = (retry >= 4'(MAX_RETRY));
    assign grant_onehot = NUM_REQ'(1) << grant_idx;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            retry        <= '0;
            timer        <= '0;
            load_cnt     <= 1'b0;
            done         <= '0;
            done_ok      <= 1'b0;
            busy         <= 1'b0;
            tx_start     <= 1'b0;
            tx_package_o <= '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
        end else begin
            tx_start <= 1'b0;
            done     <= '0;
            done_ok  <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant_idx    <= arb_grant;
                        tx_package_o <= req_package[int'(arb_grant)*CTRL_PKG_BITS +: CTRL_PKG_BITS];
                        retry        <= '0;
                        load_cnt     <= 1'b0;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end
                // Two setup cycles: the transceiver latches its package a cycle late.
                LOAD: begin
                    if (load_cnt) begin
                        tx_start <= 1'b1;
                        state    <= START;
                    end else begin
                        load_cnt <= 1'b1;
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    timer <= timer + TW'(1);
                    if (tx_done) begin
                        state <= WAIT_RX;
                    end else if (timed_out) begin
                        state    <= FAIL;
                        fail_cnt <= sat_inc(fail_cnt);
                        if (last_try) done <= grant_onehot;
                    end
                end
                // A pass in the timeout cycle still counts as a pass.
                WAIT_RX: begin
                    timer <= timer + TW'(1);
                    if (rx_ok) begin
                        state    <= PASS;
                        done     <= grant_onehot;
                        done_ok  <= 1'b1;
                        pass_cnt <= sat_inc(pass_cnt);
                    end else if (timed_out) begin
                        state    <= FAIL;
                        fail_cnt <= sat_inc(fail_cnt);
                        if (last_try) done <= grant_onehot;
                    end
                end
                PASS: begin
                    rr_ptr <= next_ptr(grant_idx);
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                FAIL: begin
                    if (!last_try) begin
                        retry    <= retry + 4'd1;
                        tx_start <= 1'b1;
                        state    <= START;
                    end else begin
                        rr_ptr <= next_ptr(grant_idx);
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_link_scheduler.sv
// Scoreboard bench for ctrl_link_scheduler: randomized requesters and a
// behavioural transceiver; expectations are queued at grant and checked at done.
module tb_ctrl_link_scheduler;

    localparam int NUM_REQ     = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int MAX_RETRY   = 3;
    localparam int TW          = 7;

    logic                     sys_clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*128-1:0]   req_package;
    logic [NUM_REQ-1:0]       done;
    logic                     done_ok;
    logic                     busy;
    logic                     tx_start;
    logic [127:0]             tx_package_o;
    logic                     tx_done;
    logic                     rx_good;
    logic [7:0]               rx_bit_cnt;
    logic [15:0]              pass_cnt;
    logic [15:0]              fail_cnt;

    ctrl_link_scheduler #(
        .NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY), .TW(TW)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .req(req), .req_package(req_package),
        .done(done), .done_ok(done_ok), .busy(busy), .tx_start(tx_start),
        .tx_package_o(tx_package_o), .tx_done(tx_done), .rx_good(rx_good),
        .rx_bit_cnt(rx_bit_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        int           grant;
        logic [127:0] pkg;
        int           plan;      // failing attempts before the passing one; > MAX_RETRY = never passes
        int           grant_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int checks = 0;
    int errors = 0;

    // Controls written only by the main stimulus process.
    int plan_mode      = 0;
    int fail_kind_mode = -1;
    int sat_seq        = 0;
    bit end_req        = 1'b0;

    // Requests as seen by the DUT on the rising edge.
    logic [NUM_REQ-1:0]     req_q;
    logic [NUM_REQ*128-1:0] pkg_q;
    always @(posedge sys_clk) begin
        req_q <= req;
        pkg_q <= req_package;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int k = 0; k < NUM_REQ; k++)
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    // Monitor, reference model and transceiver model.
    int          cyc = 0;
    int          mptr = 0;
    logic [15:0] mpass = 0;
    logic [15:0] mfail = 0;
    int          sat_seen = 0;
    bit          busy_prev = 0;
    bit          end_done = 0;
    int          starts = 0;
    int          last_start = 0;
    int          good_cyc = 0;
    int          busy_len = 0;
    bit          tx_active = 0;
    int          tkind = 0;   // 0 silent, 1 tx only, 2 wrong bit count, 3 pass
    int          td1 = 0;
    int          td2 = 0;
    int          tcnt = 0;
    int          g;
    bit          ok;
    int          nf;

    initial begin
        tx_done    = 1'b0;
        rx_good    = 1'b0;
        rx_bit_cnt = 8'd0;
    end

    always @(negedge sys_clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_done", done, 0);
            chk("rst_done_ok", done_ok, 0);
            chk("rst_busy", busy, 0);
            chk("rst_tx_start", tx_start, 0);
            chk("rst_tx_package", tx_package_o, 0);
            chk("rst_pass_cnt", pass_cnt, 0);
            chk("rst_fail_cnt", fail_cnt, 0);
            exp_q.delete();
            mptr = 0; mpass = 0; mfail = 0;
            busy_prev = 0; tx_active = 0; starts = 0; busy_len = 0;
            tx_done = 1'b0; rx_good = 1'b0; rx_bit_cnt = 8'd0;
        end else begin
            if (sat_seq != sat_seen) begin
                sat_seen = sat_seq;
                mpass = 16'hFFFE;
            end

            if (busy && !busy_prev) begin
                g = rr_pick(req_q, mptr);
                if (g < 0) begin
                    chk("grant_without_req", busy, 0);
                end else begin
                    e.grant = g;
                    e.pkg = pkg_q[g*128 +: 128];
                    if (plan_mode < 0)
                        e.plan = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, MAX_RETRY + 1));
                    else
                        e.plan = plan_mode;
                    e.grant_cyc = cyc;
                    exp_q.push_back(e);
                end
                starts = 0;
                busy_len = 0;
            end
            busy_prev = busy;

            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    chk("tx_start_unexpected", tx_start, 0);
                end else begin
                    starts++;
                    chk("tx_package", tx_package_o, exp_q[0].pkg);
                    if (starts == 1) chk("start_latency", cyc - exp_q[0].grant_cyc, 2);
                    else             chk("retry_spacing", cyc - last_start, TIMEOUT_CYC + 2);
                    last_start = cyc;
                    tx_done = 1'b0; rx_good = 1'b0; rx_bit_cnt = 8'd0;
                    tx_active = 1; tcnt = 0;
                    td1 = $urandom_range(1, 8);
                    td2 = $urandom_range(1, 8);
                    if (starts - 1 == exp_q[0].plan) tkind = 3;
                    else if (fail_kind_mode < 0)     tkind = $urandom_range(0, 2);
                    else                             tkind = fail_kind_mode;
                end
            end else if (tx_active) begin
                tcnt++;
                if (tcnt == td1 && tkind != 0) tx_done = 1'b1;
                if (tcnt == td1 + td2 && tkind >= 2) begin
                    rx_good = 1'b1;
                    rx_bit_cnt = (tkind == 3) ? 8'd144 : 8'd143;
                    if (tkind == 3) good_cyc = cyc;
                end
            end

            if (done != '0) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    e = exp_q.pop_front();
                    ok = (e.plan <= MAX_RETRY);
                    nf = ok ? e.plan : MAX_RETRY + 1;
                    chk("done_vec", done, NUM_REQ'(1) << e.grant);
                    chk("done_ok", done_ok, ok);
                    chk("attempts", starts, ok ? e.plan + 1 : MAX_RETRY + 1);
                    if (ok) chk("done_latency", cyc - good_cyc, 1);
                    chk("done_package", tx_package_o, e.pkg);
                    if (ok && mpass != 16'hFFFF) mpass = mpass + 16'd1;
                    mfail = (int'(mfail) + nf > 65535) ? 16'hFFFF : mfail + 16'(nf);
                    chk("pass_cnt", pass_cnt, mpass);
                    chk("fail_cnt", fail_cnt, mfail);
                    mptr = (e.grant + 1) % NUM_REQ;
                end
                tx_active = 0;
            end else if (done_ok) begin
                chk("done_ok_without_done", done_ok, 0);
            end

            if (busy) begin
                busy_len++;
                if (busy_len > (MAX_RETRY + 1) * (TIMEOUT_CYC + 2) + 16) begin
                    chk("stall", busy_len, 0);
                    busy_len = 0;
                end
            end

            if (end_req && !end_done) begin
                end_done = 1;
                chk("drain", exp_q.size(), 0);
                chk("final_pass_cnt", pass_cnt, mpass);
                chk("final_fail_cnt", fail_cnt, mfail);
            end
        end
    end

    task automatic run_reqs(input logic [NUM_REQ-1:0] mask, input int n, input bit rgap);
        int got = 0;
        int guard = 0;
        int gap[NUM_REQ];
        for (int i = 0; i < NUM_REQ; i++) gap[i] = 0;
        req = mask;
        while (got < n && guard < 20000) begin
            @(negedge sys_clk);
            guard++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done[i]) begin
                    got++;
                    req_package[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
                    if (rgap && $urandom_range(0, 1) == 1) begin
                        req[i] = 1'b0;
                        gap[i] = $urandom_range(1, 6);
                    end
                end else if (gap[i] > 0) begin
                    gap[i]--;
                    if (gap[i] == 0) req[i] = 1'b1;
                end
            end
        end
        req = '0;
        guard = 0;
        do begin
            @(negedge sys_clk);
            guard++;
        end while (busy && guard < 5000);
        @(negedge sys_clk);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        req = '0;
        req_package = '0;
        repeat (3) @(negedge sys_clk);
        #2 rst_n = 1'b1;

        // Single pass on requester 0 with a known package.
        req_package[127:0] = 128'h0123456789ABCDEF0123456789ABCDEF;
        plan_mode = 0;
        run_reqs(2'b01, 1, 1'b0);

        // Both requesters held for four transactions.
        req_package = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_reqs(2'b11, 4, 1'b0);

        // Broken link: every attempt times out.
        plan_mode = MAX_RETRY + 1;
        run_reqs(2'b01, 1, 1'b0);

        // First attempt fails, second passes.
        plan_mode = 1;
        run_reqs(2'b10, 1, 1'b0);

        // Reset while waiting for loop-back.
        plan_mode = MAX_RETRY + 1;
        fail_kind_mode = 1;
        req = 2'b01;
        guard = 0;
        while (!tx_start && guard < 100) begin
            @(negedge sys_clk);
            guard++;
        end
        repeat (12) @(negedge sys_clk);
        #2 rst_n = 1'b0;
        req = '0;
        repeat (2) @(negedge sys_clk);
        #2 rst_n = 1'b1;
        fail_kind_mode = -1;
        plan_mode = 0;
        run_reqs(2'b11, 2, 1'b0);

        // Pass counter saturation.
        @(negedge sys_clk);
        #2 force dut.pass_cnt = 16'hFFFE;
        #1 release dut.pass_cnt;
        sat_seq++;
        run_reqs(2'b01, 3, 1'b0);

        // Randomized traffic.
        plan_mode = -1;
        run_reqs(2'b11, 30, 1'b1);

        end_req = 1'b1;
        repeat (3) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
